// File: rtl/sprite_line_sequencer.sv
// Per-scanline sprite walker: queries the matcher for every table index and streams
// one fetch command per chunk of each hit sprite under valid/ready flow control.
module sprite_line_sequencer #(
    parameter int NUM_SPRITES  = 512,
    parameter int IDX_W        = $clog2(NUM_SPRITES),
    parameter int MAX_PER_LINE = 64,
    parameter int CNT_W        = 8,
    parameter int LBX_W        = 12,
    parameter int STEP         = 8,
    parameter int MATCH_LAT    = 1
) (
    input  logic                                   clk_draw,
    input  logic                                   rst_draw_n,
    input  logic                                   enable,
    input  logic                                   line_start,
    output logic                                   query_req,
    output logic [IDX_W-1:0]                       query_idx,
    input  logic                                   hit,
    input  logic [CNT_W-1:0]                       hit_count,
    input  logic [LBX_W-1:0]                       hit_lb_x,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [IDX_W-1:0]                       out_sprite,
    output logic [CNT_W-1:0]                       out_chunk,
    output logic [LBX_W-1:0]                       out_lb_x,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   overflow,
    output logic [$clog2(MAX_PER_LINE+1)-1:0]      sprites_drawn
);
    localparam int SD_W  = $clog2(MAX_PER_LINE + 1);
    localparam int LAT_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;

    typedef enum logic [2:0] {IDLE, QUERY, WAIT, EMIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [SD_W-1:0]   drawn_reg, drawn_next;
    logic              overflow_reg, overflow_next;
    logic [LAT_W-1:0]  lat_reg, lat_next;
    logic [LBX_W-1:0]  lb_x_reg, lb_x_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  chunk_reg, chunk_next;
    logic              last_chunk;
    logic              at_end;

    assign last_chunk = (chunk_reg == count_reg - CNT_W'(1));
    assign at_end     = (idx_reg == IDX_W'(NUM_SPRITES - 1));

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            drawn_reg    <= '0;
            overflow_reg <= 1'b0;
            lat_reg      <= '0;
            lb_x_reg     <= '0;
            count_reg    <= '0;
            chunk_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            drawn_reg    <= drawn_next;
            overflow_reg <= overflow_next;
            lat_reg      <= lat_next;
            lb_x_reg     <= lb_x_next;
            count_reg    <= count_next;
            chunk_reg    <= chunk_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        drawn_next    = drawn_reg;
        overflow_next = overflow_reg;
        lat_next      = lat_reg;
        lb_x_next     = lb_x_reg;
        count_next    = count_reg;
        chunk_next    = chunk_reg;

        case (state_reg)
            QUERY: begin
                state_next = WAIT;
                lat_next   = LAT_W'(MATCH_LAT - 1);
            end
            WAIT: begin
                if (lat_reg != '0) begin
                    lat_next = lat_reg - LAT_W'(1);
                end else if (hit && hit_count != '0) begin
                    if (drawn_reg < SD_W'(MAX_PER_LINE)) begin
                        lb_x_next  = hit_lb_x;
                        count_next = hit_count;
                        chunk_next = '0;
                        state_next = EMIT;
                    end else begin
                        // Budget exhausted: the remainder of the table is skipped.
                        overflow_next = 1'b1;
                        state_next    = DONE;
                    end
                end else if (at_end) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = QUERY;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_chunk) begin
                        drawn_next = drawn_reg + SD_W'(1);
                        if (at_end) begin
                            state_next = DONE;
                        end else begin
                            idx_next   = idx_reg + IDX_W'(1);
                            state_next = QUERY;
                        end
                    end else begin
                        chunk_next = chunk_reg + CNT_W'(1);
                        lb_x_next  = lb_x_reg + LBX_W'(STEP);
                    end
                end
            end
            default: ;
        endcase

        // A new line overrides whatever the current line was doing.
        if (line_start) begin
            idx_next      = '0;
            drawn_next    = '0;
            overflow_next = 1'b0;
            state_next    = enable ? QUERY : DONE;
        end
    end

    assign query_req     = (state_reg == QUERY);
    assign query_idx     = idx_reg;
    assign out_valid     = (state_reg == EMIT);
    assign out_sprite    = idx_reg;
    assign out_chunk     = chunk_reg;
    assign out_lb_x      = lb_x_reg;
    assign out_last      = (state_reg == EMIT) && last_chunk;
    assign busy          = (state_reg == QUERY) || (state_reg == WAIT) || (state_reg == EMIT);
    assign overflow      = overflow_reg;
    assign sprites_drawn = drawn_reg;
endmodule

// File: tb/tb_sprite_line_sequencer.sv
// Scoreboard bench for sprite_line_sequencer with a fixed-latency matcher model.
module tb_sprite_line_sequencer;
    localparam int NUM_SPRITES  = 4;
    localparam int IDX_W        = 2;
    localparam int MAX_PER_LINE = 2;
    localparam int CNT_W        = 8;
    localparam int LBX_W        = 12;
    localparam int STEP         = 8;
    localparam int MATCH_LAT    = 2;
    localparam int SD_W         = $clog2(MAX_PER_LINE + 1);

    logic              clk_draw = 1'b0;
    logic              rst_draw_n = 1'b1;
    logic              enable = 1'b0;
    logic              line_start = 1'b0;
    logic              query_req;
    logic [IDX_W-1:0]  query_idx;
    logic              hit;
    logic [CNT_W-1:0]  hit_count;
    logic [LBX_W-1:0]  hit_lb_x;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_sprite;
    logic [CNT_W-1:0]  out_chunk;
    logic [LBX_W-1:0]  out_lb_x;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic [SD_W-1:0]   sprites_drawn;

    sprite_line_sequencer #(
        .NUM_SPRITES(NUM_SPRITES), .IDX_W(IDX_W), .MAX_PER_LINE(MAX_PER_LINE),
        .CNT_W(CNT_W), .LBX_W(LBX_W), .STEP(STEP), .MATCH_LAT(MATCH_LAT)
    ) dut (
        .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .enable(enable),
        .line_start(line_start), .query_req(query_req), .query_idx(query_idx),
        .hit(hit), .hit_count(hit_count), .hit_lb_x(hit_lb_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_sprite(out_sprite),
        .out_chunk(out_chunk), .out_lb_x(out_lb_x), .out_last(out_last),
        .busy(busy), .overflow(overflow), .sprites_drawn(sprites_drawn)
    );

    always #5 clk_draw = ~clk_draw;

    typedef struct packed {
        logic [IDX_W-1:0] sprite;
        logic [CNT_W-1:0] chunk;
        logic [LBX_W-1:0] lbx;
        logic             last;
    } cmd_t;

    cmd_t              exp_q[$];
    logic              tbl_hit [NUM_SPRITES];
    logic [CNT_W-1:0]  tbl_cnt [NUM_SPRITES];
    logic [LBX_W-1:0]  tbl_lbx [NUM_SPRITES];
    bit                pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int                tests_run = 0;
    int                tests_failed = 0;
    int                cyc = 0;
    int                start_cyc = 0;
    int                xfers = 0;
    int                q_seen [NUM_SPRITES];
    int                exp_drawn, exp_queries, exp_chunks;
    logic              exp_ovf;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Matcher model: answers exactly MATCH_LAT (=2) cycles after each query strobe.
    logic             m_v1 = 1'b0, m_v2 = 1'b0;
    logic [IDX_W-1:0] m_i1 = '0, m_i2 = '0;
    always @(posedge clk_draw) begin
        m_v1 <= query_req;
        m_i1 <= query_idx;
        m_v2 <= m_v1;
        m_i2 <= m_i1;
    end
    assign hit       = m_v2 && tbl_hit[m_i2];
    assign hit_count = m_v2 ? tbl_cnt[m_i2] : '0;
    assign hit_lb_x  = m_v2 ? tbl_lbx[m_i2] : '0;

    always @(posedge clk_draw) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    cmd_t held;
    logic held_vld = 1'b0;
    always @(negedge clk_draw) begin
        cmd_t cur;
        cmd_t e;
        cur = {out_sprite, out_chunk, out_lb_x, out_last};
        if (query_req) q_seen[query_idx]++;
        if (held_vld && out_valid)
            check_value("stall_hold", 32'(cur), 32'(held));
        if (rst_draw_n && out_valid && out_ready) begin
            xfers++;
            check_value("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("[TB] cmd sprite=%0d chunk=%0d lb_x=0x%03h last=%0d", out_sprite, out_chunk, out_lb_x, out_last);
                check_value("out_sprite", 32'(out_sprite), 32'(e.sprite));
                check_value("out_chunk", 32'(out_chunk), 32'(e.chunk));
                check_value("out_lb_x", 32'(out_lb_x), 32'(e.lbx));
                check_value("out_last", 32'(out_last), 32'(e.last));
            end
        end
        held_vld = rst_draw_n && out_valid && !out_ready;
        held     = cur;
    end

    task automatic build_expected(input bit en);
        int n;
        n = 0;
        exp_q.delete();
        exp_queries = 0;
        exp_chunks  = 0;
        exp_ovf     = 1'b0;
        if (en) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                exp_queries++;
                if (tbl_hit[i] && tbl_cnt[i] != 0) begin
                    if (n == MAX_PER_LINE) begin
                        exp_ovf = 1'b1;
                        break;
                    end
                    for (int c = 0; c < int'(tbl_cnt[i]); c++)
                        exp_q.push_back(cmd_t'({IDX_W'(i), CNT_W'(c),
                            LBX_W'(tbl_lbx[i] + LBX_W'(c * STEP)), 1'(c == int'(tbl_cnt[i]) - 1)}));
                    exp_chunks += int'(tbl_cnt[i]);
                    n++;
                end
            end
        end
        exp_drawn = n;
    endtask

    task automatic set_entry(input int i, input logic h, input logic [CNT_W-1:0] c, input logic [LBX_W-1:0] x);
        tbl_hit[i] = h;
        tbl_cnt[i] = c;
        tbl_lbx[i] = x;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NUM_SPRITES; i++) set_entry(i, 1'b0, '0, '0);
    endtask

    task automatic start_line(input bit en, input logic rdy);
        @(posedge clk_draw); #1;
        enable     = en;
        line_start = 1'b1;
        out_ready  = rdy;
        xfers      = 0;
        for (int i = 0; i < NUM_SPRITES; i++) q_seen[i] = 0;
        @(negedge clk_draw);
        start_cyc = cyc;
    endtask

    task automatic finish_line(input string tag, input bit en, input bit stall, input bit chk_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk_draw); #1;
            if (k == 0) line_start = 1'b0;
            out_ready = stall ? pat[k % 4] : 1'b1;
            @(negedge clk_draw);
            if (k == 0) begin
                check_value({tag, "_first_query"}, 32'(query_req), 32'(en));
                check_value({tag, "_first_idx"}, 32'(query_idx), 32'd0);
                check_value({tag, "_valid_low"}, 32'(out_valid), 32'd0);
            end
            if (!busy) done = 1'b1;
        end
        check_value({tag, "_done"}, 32'(done), 32'd1);
        if (chk_cyc)
            check_value({tag, "_cycles"}, 32'(cyc - start_cyc),
                        32'(exp_queries * (MATCH_LAT + 1) + exp_chunks + 1));
        check_value({tag, "_drawn"}, 32'(sprites_drawn), 32'(exp_drawn));
        check_value({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check_value({tag, "_xfers"}, 32'(xfers), 32'(exp_chunks));
        check_value({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NUM_SPRITES; i++)
            check_value($sformatf("%s_query%0d", tag, i), 32'(q_seen[i]), (i < exp_queries) ? 32'd1 : 32'd0);
        $display("[TB] line %s: drawn=%0d overflow=%0d xfers=%0d", tag, sprites_drawn, overflow, xfers);
    endtask

    initial begin
        bit seen;
        clear_table();
        for (int i = 0; i < NUM_SPRITES; i++) q_seen[i] = 0;
        #1 rst_draw_n = 1'b0;
        #1;
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_valid", 32'(out_valid), 32'd0);
        check_value("rst_query", 32'(query_req), 32'd0);
        check_value("rst_drawn", 32'(sprites_drawn), 32'd0);
        check_value("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk_draw); #1 rst_draw_n = 1'b1;
        repeat (3) @(negedge clk_draw);
        check_value("idle_busy", 32'(busy), 32'd0);

        // Single hit at idx 2 with an lb_x that wraps across the line buffer end.
        clear_table();
        set_entry(2, 1'b1, 8'd3, 12'hFF8);
        build_expected(1'b1);
        start_line(1'b1, 1'b1);
        finish_line("wrap", 1'b1, 1'b0, 1'b1);

        // Same sprite with ready toggling 1,0,0,1.
        build_expected(1'b1);
        start_line(1'b1, 1'b1);
        finish_line("stall", 1'b1, 1'b1, 1'b0);

        // Every entry hits: the per-line budget of two runs out at idx 2.
        for (int i = 0; i < NUM_SPRITES; i++) set_entry(i, 1'b1, 8'd1, 12'(16 * i + 4));
        build_expected(1'b1);
        start_line(1'b1, 1'b1);
        finish_line("budget", 1'b1, 1'b0, 1'b1);

        // Zero-count hit behaves as a miss; last index hits.
        clear_table();
        set_entry(1, 1'b1, 8'd0, 12'h050);
        set_entry(3, 1'b1, 8'd2, 12'h100);
        build_expected(1'b1);
        start_line(1'b1, 1'b1);
        finish_line("zerocnt", 1'b1, 1'b0, 1'b1);

        // Disabled line: nothing queried, busy never rises.
        build_expected(1'b0);
        start_line(1'b0, 1'b1);
        finish_line("disabled", 1'b0, 1'b0, 1'b1);

        // Abort a 4-chunk sprite while chunk 1 is on the bus.
        clear_table();
        set_entry(1, 1'b1, 8'd4, 12'h010);
        build_expected(1'b1);
        start_line(1'b1, 1'b1);
        @(posedge clk_draw); #1 line_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_draw);
            if (out_valid && out_chunk == 8'd0) seen = 1'b1;
            else begin @(posedge clk_draw); #1; end
        end
        check_value("abort_reach_chunk0", 32'(seen), 32'd1);
        start_line(1'b1, 1'b0);
        check_value("abort_in_chunk1", 32'(out_chunk), 32'd1);
        clear_table();
        build_expected(1'b1);
        finish_line("abort", 1'b1, 1'b0, 1'b1);

        // Asynchronous reset while the second sprite is emitting.
        clear_table();
        set_entry(0, 1'b1, 8'd1, 12'h020);
        set_entry(1, 1'b1, 8'd3, 12'h040);
        build_expected(1'b1);
        start_line(1'b1, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk_draw); #1;
            line_start = 1'b0;
            @(negedge clk_draw);
            if (out_valid && out_sprite == 2'd1) seen = 1'b1;
        end
        check_value("rstmid_reach", 32'(seen), 32'd1);
        @(posedge clk_draw); #1 out_ready = 1'b0;
        check_value("rstmid_pre_drawn", 32'(sprites_drawn), 32'd1);
        #2 rst_draw_n = 1'b0;
        #1;
        check_value("rstmid_valid", 32'(out_valid), 32'd0);
        check_value("rstmid_busy", 32'(busy), 32'd0);
        check_value("rstmid_query", 32'(query_req), 32'd0);
        check_value("rstmid_drawn", 32'(sprites_drawn), 32'd0);
        check_value("rstmid_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_draw);
        #1 rst_draw_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_draw);
            check_value("rstmid_idle_busy", 32'(busy), 32'd0);
            check_value("rstmid_idle_query", 32'(query_req), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
